// File: rtl/nihilist_encrypt_stream_if.sv
// Plaintext-in / cipher-out handshake bundle for the Nihilist stream encryptor.
// The master side supplies letters and consumes cipher bytes.
interface nihilist_encrypt_stream_if;
  logic       i_w_valid;
  logic [7:0] i_w_char;
  logic       i_w_last;
  logic       o_w_ready;
  logic       o_r_valid;
  logic [7:0] o_r_cipher;
  logic       i_w_ready;

  modport master (
    output i_w_valid, i_w_char, i_w_last, i_w_ready,
    input  o_w_ready, o_r_valid, o_r_cipher
  );

  modport slave (
    input  i_w_valid, i_w_char, i_w_last, i_w_ready,
    output o_w_ready, o_r_valid, o_r_cipher
  );
endinterface

// File: rtl/nihilist_encrypt_stream.sv
// Serial Nihilist encryptor: one letter in, one cipher byte out (letter code + key code),
// using the DANIEL Polybius square with I/J merged and a cycling secret.
module nihilist_encrypt_stream #(
  parameter int p_secret_length = 6
) (
  input  logic                         i_w_clk,
  input  logic                         i_w_rst,
  input  logic [p_secret_length*8-1:0] i_w_secret,
  input  logic                         i_w_start,
  nihilist_encrypt_stream_if.slave     stream,
  output logic                         o_r_done,
  output logic                         o_r_error,
  output logic [7:0]                   o_r_count
);
  localparam int KW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [6:0]   key_code_q [p_secret_length];
  logic [KW-1:0] key_idx_q;
  logic         valid_q;
  logic [7:0]   cipher_q;
  logic         done_q;
  logic         error_q;
  logic [7:0]   count_q;
  logic         ready;
  logic         xfer;
  logic         secret_ok;
  logic [6:0]   char_code;
  logic [7:0]   sum;

  // Square code of a letter (row*10+col); 0 marks an invalid byte.
  function automatic logic [6:0] sq_code(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      "D": sq_code = 7'd11;  "A": sq_code = 7'd12;  "N": sq_code = 7'd13;
      "I": sq_code = 7'd14;  "J": sq_code = 7'd14;  "E": sq_code = 7'd15;
      "L": sq_code = 7'd21;  "B": sq_code = 7'd22;  "C": sq_code = 7'd23;
      "F": sq_code = 7'd24;  "G": sq_code = 7'd25;
      "H": sq_code = 7'd31;  "K": sq_code = 7'd32;  "M": sq_code = 7'd33;
      "O": sq_code = 7'd34;  "P": sq_code = 7'd35;
      "Q": sq_code = 7'd41;  "R": sq_code = 7'd42;  "S": sq_code = 7'd43;
      "T": sq_code = 7'd44;  "U": sq_code = 7'd45;
      "V": sq_code = 7'd51;  "W": sq_code = 7'd52;  "X": sq_code = 7'd53;
      "Y": sq_code = 7'd54;  "Z": sq_code = 7'd55;
      default: sq_code = '0;
    endcase
  endfunction

  always_comb begin
    secret_ok = 1'b1;
    for (int unsigned i = 0; i < p_secret_length; i++) begin
      if (sq_code(i_w_secret[i*8 +: 8]) == '0) secret_ok = 1'b0;
    end
  end

  assign char_code = sq_code(stream.i_w_char);
  assign sum       = 8'(char_code) + 8'(key_code_q[key_idx_q]);

  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE:  if (i_w_start && secret_ok) state_d = RUN;
      RUN: begin
        ready = !valid_q || stream.i_w_ready;
        xfer  = ready && stream.i_w_valid;
        if (xfer && stream.i_w_last) state_d = DRAIN;
      end
      DRAIN: if (valid_q && stream.i_w_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      for (int unsigned i = 0; i < p_secret_length; i++) key_code_q[i] <= '0;
      key_idx_q <= '0;
      valid_q   <= 1'b0;
      cipher_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_w_start) begin
          // Secret byte 0 sits in the MSBs, so key slot i comes from the top down.
          for (int unsigned i = 0; i < p_secret_length; i++)
            key_code_q[i] <= sq_code(i_w_secret[(p_secret_length-1-i)*8 +: 8]);
          key_idx_q <= '0;
          count_q   <= '0;
          error_q   <= !secret_ok;
        end
        RUN: begin
          if (xfer) begin
            valid_q <= 1'b1;
            if (char_code != '0) begin
              cipher_q  <= sum;
              key_idx_q <= (key_idx_q == KW'(p_secret_length-1)) ? '0 : key_idx_q + 1'b1;
              if (count_q != '1) count_q <= count_q + 8'd1;
            end else begin
              cipher_q <= '0;
              error_q  <= 1'b1;
            end
          end else if (valid_q && stream.i_w_ready) begin
            valid_q <= 1'b0;
          end
        end
        DRAIN: if (valid_q && stream.i_w_ready) begin
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stream.o_w_ready  = ready;
  assign stream.o_r_valid  = valid_q;
  assign stream.o_r_cipher = cipher_q;
  assign o_r_done          = done_q;
  assign o_r_error         = error_q;
  assign o_r_count         = count_q;
endmodule

// File: doc/nihilist_encrypt_stream.md
Name: nihilist_encrypt_stream

Overview:
- Serial Polybius/Nihilist encryptor. Consumes one plaintext letter per handshake and produces one cipher byte per letter.
- Each cipher byte is the decimal sum of the letter's square code and the current secret letter's square code. The secret letter cycles with wrap-around.
- Sits directly upstream of the combinational decrypt block. Its byte stream, packed first-byte-in-MSBs, is exactly the cipher format decrypt consumes.

Parameters:
- p_secret_length, 6, number of secret characters.

Ports:
- i_w_clk  in  1  clock, rising edge.
- i_w_rst  in  1  synchronous, active-high reset.
- i_w_secret  in  p_secret_length*8  ASCII secret; first character in the MSB byte. Sampled only on start.
- i_w_start  in  1  begin a message. Honoured only in IDLE.
- i_w_valid  in  1  plaintext byte valid.
- i_w_char  in  8  ASCII plaintext byte.
- i_w_last  in  1  qualifies i_w_char as the final letter of the message.
- o_w_ready  out  1  upstream may transfer (valid && ready).
- o_r_valid  out  8→1  cipher byte valid.
- o_r_cipher  out  8  cipher byte (binary value of the decimal sum, 22..110).
- i_w_ready  in  1  downstream accepts the cipher byte.
- o_r_done  out  1  one-cycle pulse when the last cipher byte is accepted.
- o_r_error  out  1  sticky; cleared on reset or on an accepted start.
- o_r_count  out  8  letters encrypted in the current message; saturates at 255.

Behaviour:
- Square is fixed, keyword DANIEL, I/J merged, code = row*10+col:
  - row1: D A N I E
  - row2: L B C F G
  - row3: H K M O P
  - row4: Q R S T U
  - row5: V W X Y Z
  - Lowercase folds to uppercase.
  - J encodes as I (14).
  - Any other byte is invalid.
- Reset: state IDLE. o_r_valid=0, o_r_cipher=0, o_r_done=0, o_r_error=0, o_r_count=0, key index=0.
- IDLE:
  - o_w_ready=0.
  - On i_w_start: latch i_w_secret, key index=0, count=0, error=0.
  - If any secret byte is invalid: error=1 and remain IDLE. Otherwise go to RUN.
- RUN:
  - o_w_ready = !o_r_valid || i_w_ready (single output register, full throughput).
  - On transfer of a valid letter, the next cycle has o_r_valid=1 and o_r_cipher = code(char) + code(secret[key index]).
  - Key index then advances; it wraps from p_secret_length-1 to 0. Count increments.
  - Invalid letter: it is consumed. Output byte is 0x00 with o_r_valid=1, error set, key index unchanged, count unchanged.
  - Transfer with i_w_last: go to DRAIN.
- DRAIN:
  - o_w_ready=0.
  - When o_r_valid && i_w_ready: o_r_valid=0, o_r_done=1 for one cycle, go to IDLE.
- Output hold: o_r_cipher and o_r_valid stay stable while o_r_valid && !i_w_ready.
- Latency: exactly 1 cycle from input transfer to o_r_valid.
- Ignored inputs: i_w_start outside IDLE; i_w_valid in IDLE and DRAIN.
- Reset has priority over everything. Reset mid-message discards the held byte and returns to IDLE with all outputs at their reset values.
- Simultaneous output accept and new input transfer in RUN: the register reloads in the same cycle with no bubble.

Test Plan:
- Start, secret "DANILA", stream "TEXT", i_w_ready=1 → bytes 0x37, 0x1B, 0x42, 0x3A on consecutive cycles; o_r_count=4.
- Full 27-letter "TEXTFOARTELUNGDEMULTELITERE" with secret "DANILA", last on the final E → 216-bit concatenation equals 0x371B423A2D2E1736391D2A3918251... (55,27,66,58,45,46,23,54,...,54,28). o_r_done pulses once. Feeding the packed result into decrypt returns the text.
- Key wrap: 7th letter A after six letters → key D, byte 23 (0x17). Lowercase "t" first → 0x37. "J" with key D → 25 (0x19).
- Backpressure: i_w_ready low 3 cycles mid-stream → o_w_ready=0, o_r_cipher held, no letter lost or duplicated, order preserved.
- Invalid letter '5' → byte 0x00, o_r_error=1 and sticky. Next letter still uses the unadvanced key letter. Secret "DAN1LA" at start → error=1, block stays IDLE.
- Reset asserted in RUN with o_r_valid=1 → next cycle all outputs 0, state IDLE, new start works normally.
